mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 150 +++++++++++++++
 tb/tb_mem_responder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Tagged line-oriented memory responder: accepts 8-beat line writes and
// 8-beat line reads over a valid/ack request/response bus.
module mem_responder #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int MEM_ADDR_BITS  = 12,
    parameter int READ_LATENCY   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_reqack,
    output logic                      bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    input  logic                      bus_respack,
    output logic                      busy
);

    localparam int LINE_BITS    = MEM_ADDR_BITS - 3;
    localparam int TAG_READ_BIT = 12;
    localparam int MEM_WORDS    = 1 << MEM_ADDR_BITS;

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        WR_RESP,
        RD_WAIT,
        RD_RESP
    } state_t;

    state_t                     r_state;
    state_t                     w_nextState;
    logic [LINE_BITS-1:0]       r_line;
    logic [LINE_BITS-1:0]       w_nextLine;
    logic [BUS_TAG_WIDTH-1:0]   r_tag;
    logic [BUS_TAG_WIDTH-1:0]   w_nextTag;
    logic [2:0]                 r_beat;
    logic [2:0]                 w_nextBeat;
    logic [3:0]                 r_lat;
    logic [3:0]                 w_nextLat;
    logic                       r_reqack;
    logic                       r_respcyc;
    logic [BUS_DATA_WIDTH-1:0]  r_resp;
    logic                       w_reqXfer;
    logic                       w_memWe;
    logic [MEM_ADDR_BITS-1:0]   w_rdIdx;
    logic [BUS_DATA_WIDTH-1:0]  r_mem [MEM_WORDS];

    assign w_reqXfer   = bus_reqcyc && r_reqack;
    assign bus_reqack  = r_reqack;
    assign bus_respcyc = r_respcyc;
    assign bus_resp    = r_resp;
    assign bus_resptag = r_tag;
    assign busy        = (r_state != IDLE);

    always_comb begin
        w_nextState = r_state;
        w_nextLine  = r_line;
        w_nextTag   = r_tag;
        w_nextBeat  = r_beat;
        w_nextLat   = r_lat;
        w_memWe     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_reqXfer) begin
                    w_nextLine  = bus_req[MEM_ADDR_BITS+2:6];
                    w_nextTag   = bus_reqtag;
                    w_nextBeat  = 3'd0;
                    w_nextLat   = 4'd0;
                    w_nextState = bus_reqtag[TAG_READ_BIT] ? RD_WAIT : WR_DATA;
                end
            end
            WR_DATA: begin
                if (w_reqXfer) begin
                    w_memWe    = 1'b1;
                    w_nextBeat = r_beat + 3'd1;
                    if (r_beat == 3'd7) begin
                        w_nextState = WR_RESP;
                    end
                end
            end
            WR_RESP: begin
                if (bus_respack) begin
                    w_nextState = IDLE;
                end
            end
            RD_WAIT: begin
                if (r_lat == 4'(READ_LATENCY - 1)) begin
                    w_nextState = RD_RESP;
                    w_nextBeat  = 3'd0;
                end else begin
                    w_nextLat = r_lat + 4'd1;
                end
            end
            RD_RESP: begin
                if (bus_respack) begin
                    w_nextBeat = r_beat + 3'd1;
                    if (r_beat == 3'd7) begin
                        w_nextState = IDLE;
                    end
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
        w_rdIdx = {r_line, w_nextBeat};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_line  <= '0;
            r_tag   <= '0;
            r_beat  <= 3'd0;
            r_lat   <= 4'd0;
        end else begin
            r_state <= w_nextState;
            r_line  <= w_nextLine;
            r_tag   <= w_nextTag;
            r_beat  <= w_nextBeat;
            r_lat   <= w_nextLat;
        end
    end

    // Bus outputs are registered from the next state so they are glitch-free
    // and read data is already fetched when a beat is first presented.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_reqack  <= 1'b0;
            r_respcyc <= 1'b0;
            r_resp    <= '0;
        end else begin
            r_reqack  <= (w_nextState == IDLE) || (w_nextState == WR_DATA);
            r_respcyc <= (w_nextState == WR_RESP) || (w_nextState == RD_RESP);
            r_resp    <= (w_nextState == RD_RESP) ? r_mem[w_rdIdx] : '0;
        end
    end

    // Storage is deliberately outside reset so aborted transactions keep data.
    always_ff @(posedge clk) begin
        if (w_memWe) begin
            r_mem[{r_line, r_beat}] <= bus_req;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios followed by
// randomized line reads/writes checked against an associative-array memory model.
module tb_mem_responder;

    localparam int DW  = 64;
    localparam int TW  = 13;
    localparam int MAB = 12;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          bus_reqcyc = 1'b0;
    logic [DW-1:0] bus_req = '0;
    logic [TW-1:0] bus_reqtag = '0;
    logic          bus_reqack;
    logic          bus_respcyc;
    logic [DW-1:0] bus_resp;
    logic [TW-1:0] bus_resptag;
    logic          bus_respack = 1'b0;
    logic          busy;

    int            compareCount = 0;
    int            failCount = 0;
    logic [63:0]   refMem [int];
    logic [63:0]   lineData [8];

    mem_responder #(
        .BUS_DATA_WIDTH(DW),
        .BUS_TAG_WIDTH (TW),
        .MEM_ADDR_BITS (MAB),
        .READ_LATENCY  (LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus_reqcyc (bus_reqcyc),
        .bus_req    (bus_req),
        .bus_reqtag (bus_reqtag),
        .bus_reqack (bus_reqack),
        .bus_respcyc(bus_respcyc),
        .bus_resp   (bus_resp),
        .bus_resptag(bus_resptag),
        .bus_respack(bus_respack),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Storage word touched by beat k of a line: the byte address wraps modulo
    // the storage size, and the line holds 8 consecutive words.
    function automatic int wordIndex(input logic [63:0] addr, input int k);
        logic [63:0] wrapped;
        wrapped = addr % (64'd1 << (MAB + 3));
        return int'(wrapped / 64) * 8 + k;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic cyc, input logic [DW-1:0] req,
                                 input logic [TW-1:0] tag, input logic ack);
        bus_reqcyc  = cyc;
        bus_req     = req;
        bus_reqtag  = tag;
        bus_respack = ack;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] observed,
                               input logic [63:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", name, observed, expected);
        end
    endtask

    task automatic doReset();
        applyStimulus(1'b0, '0, '0, 1'b0);
        reset = 1'b0;
        #1;
        checkOutput("rst_reqack", 64'(bus_reqack), 64'd0);
        checkOutput("rst_respcyc", 64'(bus_respcyc), 64'd0);
        checkOutput("rst_resp", bus_resp, 64'd0);
        checkOutput("rst_resptag", 64'(bus_resptag), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        cycle();
        cycle();
        checkOutput("rst_hold_reqack", 64'(bus_reqack), 64'd0);
        reset = 1'b1;
        #1;
        checkOutput("rst_release_reqack", 64'(bus_reqack), 64'd0);
        cycle();
        checkOutput("rst_first_edge_reqack", 64'(bus_reqack), 64'd1);
        checkOutput("rst_first_edge_busy", 64'(busy), 64'd0);
    endtask

    // Writes lineData to the line at addr; abortAt < 8 resets after that many beats.
    task automatic writeLine(input logic [63:0] addr, input logic [TW-1:0] tag,
                             input int abortAt, input int respStall);
        int n = 0;
        applyStimulus(1'b1, addr, tag, 1'b0);
        while (bus_reqack !== 1'b1 && n < 20) begin
            cycle();
            n++;
        end
        checkOutput("wr_accept_ready", 64'(bus_reqack), 64'd1);
        cycle();
        checkOutput("wr_busy", 64'(busy), 64'd1);
        for (int k = 0; k < 8; k++) begin
            if (k == abortAt) begin
                doReset();
                return;
            end
            checkOutput("wr_beat_reqack", 64'(bus_reqack), 64'd1);
            applyStimulus(1'b1, lineData[k], ~tag, 1'b0);
            cycle();
            refMem[wordIndex(addr, k)] = lineData[k];
        end
        applyStimulus(1'b0, '0, '0, 1'b0);
        for (int s = 0; s <= respStall; s++) begin
            checkOutput("wr_resp_respcyc", 64'(bus_respcyc), 64'd1);
            checkOutput("wr_resp_data", bus_resp, 64'd0);
            checkOutput("wr_resp_tag", 64'(bus_resptag), 64'(tag));
            checkOutput("wr_resp_reqack", 64'(bus_reqack), 64'd0);
            if (s < respStall) cycle();
        end
        bus_respack = 1'b1;
        cycle();
        bus_respack = 1'b0;
        checkOutput("wr_done_respcyc", 64'(bus_respcyc), 64'd0);
        checkOutput("wr_done_busy", 64'(busy), 64'd0);
    endtask

    // Reads the line at addr; stalls stallCycles at stallBeat, resets at abortBeat,
    // and with holdReq keeps bus_reqcyc high throughout the response.
    task automatic readLine(input logic [63:0] addr, input logic [TW-1:0] tag,
                            input int stallBeat, input int stallCycles,
                            input int abortBeat, input logic holdReq);
        int n = 0;
        int idx;
        applyStimulus(1'b1, addr, tag, 1'b0);
        while (bus_reqack !== 1'b1 && n < 20) begin
            cycle();
            n++;
        end
        checkOutput("rd_accept_ready", 64'(bus_reqack), 64'd1);
        cycle();
        bus_reqcyc = holdReq;
        for (int i = 0; i < LAT; i++) begin
            checkOutput("rd_wait_respcyc", 64'(bus_respcyc), 64'd0);
            checkOutput("rd_wait_busy", 64'(busy), 64'd1);
            checkOutput("rd_wait_reqack", 64'(bus_reqack), 64'd0);
            cycle();
        end
        for (int k = 0; k < 8; k++) begin
            idx = wordIndex(addr, k);
            checkOutput("rd_respcyc", 64'(bus_respcyc), 64'd1);
            checkOutput("rd_resptag", 64'(bus_resptag), 64'(tag));
            checkOutput("rd_reqack_blocked", 64'(bus_reqack), 64'd0);
            if (refMem.exists(idx)) checkOutput("rd_data", bus_resp, refMem[idx]);
            if (k == abortBeat) begin
                doReset();
                return;
            end
            if (k == stallBeat) begin
                for (int s = 0; s < stallCycles; s++) begin
                    cycle();
                    checkOutput("rd_stall_respcyc", 64'(bus_respcyc), 64'd1);
                    checkOutput("rd_stall_tag", 64'(bus_resptag), 64'(tag));
                    if (refMem.exists(idx)) checkOutput("rd_stall_data", bus_resp, refMem[idx]);
                end
            end
            bus_respack = 1'b1;
            cycle();
            bus_respack = 1'b0;
        end
        checkOutput("rd_done_respcyc", 64'(bus_respcyc), 64'd0);
        if (holdReq) checkOutput("rd_reqack_first_idle", 64'(bus_reqack), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, compared %0d", compareCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] addr;
        logic [TW-1:0] tag;
        logic isRead;
        logic [63:0] bases [5];

        #2;
        $display("[TB] reset state");
        doReset();

        $display("[TB] write 0x1040 then read 0x1047 with stall on beat 3");
        for (int k = 0; k < 8; k++) lineData[k] = 64'h1000 + 64'(k);
        writeLine(64'h1040, 13'h005, 8, 2);
        readLine(64'h1047, 13'h1006, 3, 5, -1, 1'b0);

        $display("[TB] reset during read beat 2, then re-read");
        readLine(64'h1040, 13'h1011, -1, 0, 2, 1'b0);
        readLine(64'h1040, 13'h1012, -1, 0, -1, 1'b0);

        $display("[TB] address wrap");
        for (int k = 0; k < 8; k++) lineData[k] = {$urandom, $urandom};
        writeLine((64'd1 << (MAB + 3)) + 64'h40, 13'h022, 8, 0);
        readLine(64'h40, 13'h1023, -1, 0, -1, 1'b0);

        $display("[TB] aborted write keeps partial data");
        for (int k = 0; k < 8; k++) lineData[k] = {$urandom, $urandom};
        writeLine(64'h200, 13'h031, 8, 1);
        for (int k = 0; k < 8; k++) lineData[k] = {$urandom, $urandom};
        writeLine(64'h200, 13'h032, 3, 0);
        readLine(64'h200, 13'h1033, -1, 0, -1, 1'b0);

        $display("[TB] request held during read response");
        readLine(64'h1040, 13'h1040, -1, 0, -1, 1'b1);
        readLine(64'h200, 13'h1041, -1, 0, -1, 1'b0);

        $display("[TB] randomized traffic");
        bases[0] = 64'h0;
        bases[1] = 64'h40;
        bases[2] = 64'h1040;
        bases[3] = 64'h200;
        bases[4] = 64'h7fc0;
        for (int it = 0; it < 24; it++) begin
            addr = bases[$urandom_range(0, 4)]
                 + (64'($urandom_range(0, 3)) << (MAB + 3))
                 + 64'($urandom_range(0, 63));
            isRead = refMem.exists(wordIndex(addr, 0)) ? 1'($urandom_range(0, 1)) : 1'b0;
            tag = {isRead, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255))};
            if (isRead) begin
                readLine(addr, tag, $urandom_range(0, 7), $urandom_range(0, 3), -1, 1'b0);
            end else begin
                for (int k = 0; k < 8; k++) lineData[k] = {$urandom, $urandom};
                writeLine(addr, tag, 8, $urandom_range(0, 2));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
